// File: rtl/sel_seq_pkg.sv
// sel_seq_pkg: shared states, source codes and helpers for the selector sequencer
package sel_seq_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, SHOW} state_t;
   localparam logic [1:0] SRC_A  = 2'd0;
   localparam logic [1:0] SRC_B  = 2'd1;
   localparam logic [1:0] SRC_Y  = 2'd2;
   localparam logic [1:0] SRC_OP = 2'd3;
   function automatic int cnt_width(input int dwell);
      return dwell > 1 ? $clog2(dwell) : 1;
   endfunction
   function automatic logic [3:0] onehot(input logic [1:0] s);
      return s == SRC_A ? 4'b0001 : s == SRC_B ? 4'b0010 : s == SRC_Y ? 4'b0100 : s == SRC_OP ? 4'b1000 : 4'b0000;
   endfunction
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: clearable up-counter flagging the last dwell cycle
module dwell_counter #(
   parameter int DWELL = 4,
   parameter int CW = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tc
);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (enable) cnt <= cnt + CW'(1);
   assign tc = cnt == CW'(DWELL - 1);
endmodule

// File: rtl/selector_sequencer.sv
// selector_sequencer: scans or holds a 4-way source selector and captures its output for display
module selector_sequencer
   import sel_seq_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       mode,
   input  logic       req,
   input  logic [1:0] req_src,
   input  logic [7:0] s0_in,
   output logic [3:0] select,
   output logic       ack,
   output logic [7:0] disp_data,
   output logic       disp_valid,
   output logic [1:0] cur_src
);
   localparam int CW = cnt_width(DWELL);
   state_t state;
   logic tc, adv, take, count, clear;
   logic [1:0] nxt_src;
   always_comb begin
      adv = state == SHOW && !mode && tc;
      take = state != SETTLE && (req || state == IDLE || adv);
      nxt_src = req ? req_src : adv ? cur_src + 2'd1 : cur_src;
      count = state == SHOW && !mode;
      clear = !en || !count || req || tc;
      ack = rst_n && en && req && state != SETTLE;
   end
   dwell_counter #(.DWELL(DWELL), .CW(CW)) u_dwell (
      .clk(clk),
      .rst_n(rst_n),
      .clear(clear),
      .enable(count),
      .tc(tc)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         select <= '0;
         cur_src <= SRC_A;
         disp_data <= '0;
         disp_valid <= 1'b0;
      end else begin
         disp_valid <= 1'b0;
         if (!en) begin
            state <= IDLE;
            select <= '0;
         end else if (state == SETTLE) begin
            disp_data <= s0_in;
            disp_valid <= 1'b1;
            state <= SHOW;
         end else if (take) begin
            cur_src <= nxt_src;
            select <= onehot(nxt_src);
            state <= SETTLE;
         end
      end
endmodule

// File: tb/tb_selector_sequencer.sv
// tb_selector_sequencer: directed and randomized checks of selector_sequencer against a cycle model
module tb_selector_sequencer;
   localparam int DWELL = 4;
   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, mode = 1'b0, req = 1'b0, track = 1'b0;
   logic [1:0] req_src = 2'd0;
   logic [7:0] rnd_s0 = 8'h00, s0_in;
   logic [3:0] select;
   logic ack, disp_valid;
   logic [7:0] disp_data;
   logic [1:0] cur_src;
   int total = 0, bad = 0;
   bit m_act, m_settle, m_valid;
   int m_dw, m_src;
   logic [7:0] m_data;
   always #5 clk = ~clk;
   always_comb s0_in = !track ? rnd_s0 : select[3] ? 8'h06 : select[2] ? 8'hC3 : select[1] ? 8'h0A : 8'h05;
   selector_sequencer #(.DWELL(DWELL)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .req(req), .req_src(req_src),
      .s0_in(s0_in), .select(select), .ack(ack), .disp_data(disp_data),
      .disp_valid(disp_valid), .cur_src(cur_src)
   );
   task automatic model_reset();
      m_act = 0; m_settle = 0; m_valid = 0; m_dw = 0; m_src = 0; m_data = 8'h00;
   endtask
   task automatic model_step();
      m_valid = 0;
      if (!en) begin m_act = 0; m_settle = 0; m_dw = 0; end
      else if (m_act && m_settle) begin m_data = s0_in; m_valid = 1; m_settle = 0; m_dw = 0; end
      else if (!m_act || req) begin if (req) m_src = req_src; m_act = 1; m_settle = 1; m_dw = 0; end
      else if (mode) m_dw = 0;
      else if (m_dw == DWELL - 1) begin m_src = (m_src + 1) % 4; m_settle = 1; m_dw = 0; end
      else m_dw++;
   endtask
   task automatic cyc();
      @(posedge clk);
      if (!rst_n) model_reset(); else model_step();
      #1;
   endtask
   task automatic test_reset();
      model_reset();
      en = 1; req = 1; req_src = 2'd3;
      cyc(); cyc();
      total++; if (select !== 4'b0000) begin bad++; $display("FAIL reset_select got=%b exp=0000", select); end
      total++; if (cur_src !== 2'd0) begin bad++; $display("FAIL reset_cur_src got=%0d exp=0", cur_src); end
      total++; if (disp_data !== 8'h00) begin bad++; $display("FAIL reset_disp_data got=%h exp=00", disp_data); end
      total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL reset_disp_valid got=%b exp=0", disp_valid); end
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ack); end
      req = 0; req_src = 2'd0; track = 1;
      rst_n = 1;
   endtask
   task automatic test_auto_scan();
      logic [3:0] sel_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [7:0] dat_exp [5] = '{8'h05, 8'h0A, 8'hC3, 8'h06, 8'h05};
      int n;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         do begin cyc(); n++; end while (!disp_valid && n < 20);
         total++; if (!disp_valid) begin bad++; $display("FAIL auto_valid_timeout step=%0d got=0 exp=1", k); end
         total++; if (n != (k == 0 ? 2 : DWELL + 1)) begin bad++; $display("FAIL auto_gap step=%0d got=%0d exp=%0d", k, n, k == 0 ? 2 : DWELL + 1); end
         total++; if (select !== sel_exp[k]) begin bad++; $display("FAIL auto_select step=%0d got=%b exp=%b", k, select, sel_exp[k]); end
         total++; if (disp_data !== dat_exp[k]) begin bad++; $display("FAIL auto_data step=%0d got=%h exp=%h", k, disp_data, dat_exp[k]); end
      end
   endtask
   task automatic test_manual_hold();
      int nv = 0, nbad = 0;
      mode = 1; req = 1; req_src = 2'd2;
      #1;
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL manual_ack got=%b exp=1", ack); end
      cyc(); req = 0;
      total++; if (select !== 4'b0100) begin bad++; $display("FAIL manual_select got=%b exp=0100", select); end
      total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL manual_early_valid got=%b exp=0", disp_valid); end
      cyc();
      total++; if (disp_valid !== 1'b1 || disp_data !== 8'hC3) begin bad++; $display("FAIL manual_capture got=%b/%h exp=1/c3", disp_valid, disp_data); end
      for (int i = 0; i < 3 * DWELL + 5; i++) begin
         cyc();
         if (disp_valid) nv++;
         if (select !== 4'b0100) nbad++;
      end
      total++; if (nv != 0) begin bad++; $display("FAIL manual_hold_valid got=%0d exp=0", nv); end
      total++; if (nbad != 0) begin bad++; $display("FAIL manual_hold_select got=%0d exp=0", nbad); end
   endtask
   task automatic test_req_at_expiry();
      mode = 0; req = 1; req_src = 2'd1;
      cyc(); req = 0;
      cyc();
      total++; if (cur_src !== 2'd1) begin bad++; $display("FAIL expiry_setup got=%0d exp=1", cur_src); end
      repeat (DWELL - 1) cyc();
      req = 1; req_src = 2'd0;
      #1;
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL expiry_ack got=%b exp=1", ack); end
      cyc(); req = 0;
      total++; if (cur_src !== 2'd0) begin bad++; $display("FAIL expiry_req_wins got=%0d exp=0", cur_src); end
      total++; if (select !== 4'b0001) begin bad++; $display("FAIL expiry_select got=%b exp=0001", select); end
   endtask
   task automatic test_req_in_settle();
      req = 1; req_src = 2'd3;
      #1;
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL settle_ack got=%b exp=0", ack); end
      cyc();
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL settle_deferred_ack got=%b exp=1", ack); end
      total++; if (cur_src !== 2'd0) begin bad++; $display("FAIL settle_src_kept got=%0d exp=0", cur_src); end
      cyc(); req = 0;
      total++; if (cur_src !== 2'd3 || select !== 4'b1000) begin bad++; $display("FAIL settle_taken got=%0d/%b exp=3/1000", cur_src, select); end
   endtask
   task automatic test_en_drop_and_reset();
      cyc();
      req = 1; req_src = 2'd2;
      cyc(); req = 0;
      cyc();
      total++; if (disp_data !== 8'hC3) begin bad++; $display("FAIL drop_setup got=%h exp=c3", disp_data); end
      en = 0;
      cyc();
      total++; if (select !== 4'b0000) begin bad++; $display("FAIL drop_select got=%b exp=0000", select); end
      total++; if (disp_data !== 8'hC3 || cur_src !== 2'd2) begin bad++; $display("FAIL drop_retain got=%h/%0d exp=c3/2", disp_data, cur_src); end
      total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL drop_valid got=%b exp=0", disp_valid); end
      en = 1;
      cyc();
      total++; if (select !== 4'b0100) begin bad++; $display("FAIL resume_select got=%b exp=0100", select); end
      rst_n = 0;
      #1;
      model_reset();
      total++; if (select !== 4'b0000 || cur_src !== 2'd0 || disp_data !== 8'h00 || ack !== 1'b0) begin bad++; $display("FAIL async_reset got=%b/%0d/%h/%b exp=0000/0/00/0", select, cur_src, disp_data, ack); end
      cyc();
      total++; if (disp_valid !== 1'b0 || disp_data !== 8'h00) begin bad++; $display("FAIL reset_capture got=%b/%h exp=0/00", disp_valid, disp_data); end
      rst_n = 1;
   endtask
   task automatic test_random();
      track = 0;
      for (int i = 0; i < 3000; i++) begin
         en = $urandom_range(0, 15) != 0;
         mode = $urandom_range(0, 3) == 0;
         req = $urandom_range(0, 4) == 0;
         req_src = 2'($urandom);
         rnd_s0 = 8'($urandom);
         #1;
         total++; if (ack !== (en && req && !(m_act && m_settle))) begin bad++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", i, ack, en && req && !(m_act && m_settle)); end
         cyc();
         total++; if (select !== (m_act ? 4'(1 << m_src) : 4'b0000)) begin bad++; $display("FAIL rand_select cyc=%0d got=%b exp=%b", i, select, m_act ? 4'(1 << m_src) : 4'b0000); end
         total++; if (cur_src !== 2'(m_src)) begin bad++; $display("FAIL rand_cur_src cyc=%0d got=%0d exp=%0d", i, cur_src, m_src); end
         total++; if (disp_data !== m_data) begin bad++; $display("FAIL rand_disp_data cyc=%0d got=%h exp=%h", i, disp_data, m_data); end
         total++; if (disp_valid !== m_valid) begin bad++; $display("FAIL rand_disp_valid cyc=%0d got=%b exp=%b", i, disp_valid, m_valid); end
      end
   endtask
   initial begin
      test_reset();
      test_auto_scan();
      test_manual_hold();
      test_req_at_expiry();
      test_req_in_settle();
      test_en_drop_and_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
